// File: rtl/pipe_reg_if.sv
// pipe_reg_if -- valid/ready handshake bundle for pipe_reg.
//   in_valid/in_data/in_ready    : upstream side (producer -> pipe)
//   out_valid/out_data/out_ready : downstream side (pipe -> consumer)
// Modports:
//   master : the environment around the pipe (drives in_*, out_ready)
//   slave  : the pipe itself
interface pipe_reg_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg.sv
// pipe_reg -- DEPTH-stage elastic pipeline register with collapsing bubbles.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset, clears valid and data of every stage
//   flush : synchronous clear of all stage valid bits (data left as is)
//   bus   : pipe_reg_if.slave handshake (in_* upstream, out_* downstream)
//   occ   : registered count of valid stages (only with PIPE_REG_OCC_EN)
// Optional feature macro: PIPE_REG_OCC_EN (adds the occ port and its counter).

// One stage: loads from its upstream neighbour when allowed; the data
// register only moves when a valid word is arriving.
module pipe_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (load) begin
      v <= in_v;
      if (in_v) d <= in_d;
    end
  end
endmodule

module pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  pipe_reg_if.slave                    bus
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`endif
);
  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][WIDTH-1:0] data;

  // Ready ripples from the output back: a stage can take a word if it is
  // empty or if the stage after it is moving, so bubbles collapse.
  always_comb begin
    rdy          = '0;
    rdy[DEPTH-1] = !vld[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--)
      rdy[i] = !vld[i] | rdy[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             prev_v;
    logic [WIDTH-1:0] prev_d;
    if (i == 0) begin : g_head
      assign prev_v = bus.in_valid;
      assign prev_d = bus.in_data;
    end else begin : g_body
      assign prev_v = vld[i-1];
      assign prev_d = data[i-1];
    end

    pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (rdy[i]),
      .in_v  (prev_v),
      .in_d  (prev_d),
      .v     (vld[i]),
      .d     (data[i])
    );
  end

  // Outputs come straight from the last stage's registers.
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.in_ready  = rdy[0] & !flush;

`ifdef PIPE_REG_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);
  logic in_xfer, out_xfer;
  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        occ <= '0;
    else if (flush)                 occ <= '0;
    else if (in_xfer && !out_xfer)  occ <= occ + OW'(1);
    else if (!in_xfer && out_xfer)  occ <= occ - OW'(1);
  end
`endif
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg -- directed + random self-checking bench for pipe_reg.
// Instances: DEPTH=4 main DUT and a DEPTH=1 register-slice DUT.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// on the falling edge, so "cycle c" is the window after the c-th drive.
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush1 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_reg_if #(.WIDTH(8)) bus ();
  pipe_reg_if #(.WIDTH(8)) bus1 ();

`ifdef PIPE_REG_OCC_EN
  logic [2:0] occ;
  logic [0:0] occ1;
`endif

  pipe_reg #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ   (occ)
`endif
  );

  pipe_reg #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush1),
    .bus   (bus1)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ   (occ1)
`endif
  );

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; flush = fl;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic ordy);
    @(posedge clk); #1;
    bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = ordy;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
`ifdef PIPE_REG_OCC_EN
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_latency;
    logic ev;
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, 8'(8'h11 * (c + 1)), 1'b1, 1'b0);
      @(negedge clk);
      ev = (c >= 4 && c <= 6);
      checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL latency_valid c=%0d got %0b want %0b", c, bus.out_valid, ev); end
      if (ev) begin
        checks++; if (bus.out_data !== 8'(8'h11 * (c - 3))) begin errors++; $display("FAIL latency_data c=%0d got %h want %h", c, bus.out_data, 8'(8'h11 * (c - 3))); end
      end
    end
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'(8'hA0 + c), 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.in_ready !== (c < 4)) begin errors++; $display("FAIL bp_in_ready c=%0d got %0b want %0b", c, bus.in_ready, c < 4); end
    end
`ifdef PIPE_REG_OCC_EN
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL bp_occ got %0d want 4", occ); end
`endif
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin errors++; $display("FAIL bp_drain0 got v=%0b d=%h want v=1 d=a0", bus.out_valid, bus.out_data); end
    for (int k = 1; k < 5; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hA0 + k)) begin errors++; $display("FAIL bp_drain k=%0d got v=%0b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, 8'(8'hA0 + k)); end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 4; c++) drive(1'b1, 8'(8'hB0 + c), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(8'hB4 + k), 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d got %0b want 1", k, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hB0 + k)) begin errors++; $display("FAIL b2b_out k=%0d got v=%0b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, 8'(8'hB0 + k)); end
`ifdef PIPE_REG_OCC_EN
      checks++; if (occ !== 3'd4) begin errors++; $display("FAIL b2b_occ k=%0d got %0d want 4", k, occ); end
`endif
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hB8 + k)) begin errors++; $display("FAIL b2b_drain k=%0d got v=%0b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, 8'(8'hB8 + k)); end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] nxt = 8'h00;
    logic [7:0] exp;
    for (int n = 0; n < 10008; n++) begin
      if (n < 10000) drive(1'($urandom_range(1, 0)), nxt, 1'($urandom_range(1, 0)), 1'b0);
      else           drive(1'b0, nxt, 1'b1, 1'b0);
      @(negedge clk);
`ifdef PIPE_REG_OCC_EN
      checks++; if (occ !== 3'(q.size()) || occ > 3'd4) begin errors++; if (errors < 20) $display("FAIL rnd_occ n=%0d got %0d want %0d", n, occ, q.size()); end
`endif
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; if (errors < 20) $display("FAIL rnd_extra n=%0d got %h want none", n, bus.out_data);
        end else begin
          exp = q.pop_front();
          if (bus.out_data !== exp) begin errors++; if (errors < 20) $display("FAIL rnd_data n=%0d got %h want %h", n, bus.out_data, exp); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(nxt);
        nxt = nxt + 8'd1;
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_left got %0d want 0", q.size()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    for (int c = 0; c < 3; c++) drive(1'b1, 8'(8'hC0 + c), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'hCF, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0) begin errors++; $display("FAIL flush_pre got v=%0b d=%h want v=1 d=c0", bus.out_valid, bus.out_data); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hC0) begin errors++; $display("FAIL flush_data_kept got %h want c0", bus.out_data); end
`ifdef PIPE_REG_OCC_EN
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occ); end
`endif
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak c=%0d got %0b d=%h want 0", c, bus.out_valid, bus.out_data); end
    end
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 8'hD0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.out_valid !== (c == 4) || (c == 4 && bus.out_data !== 8'hD0)) begin errors++; $display("FAIL flush_after c=%0d got v=%0b d=%h want v=%0b d=d0", c, bus.out_valid, bus.out_data, c == 4); end
    end
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < 2; c++) drive(1'b1, 8'(8'hE0 + c), 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE0) begin errors++; $display("FAIL arst_pre got v=%0b d=%h want v=1 d=e0", bus.out_valid, bus.out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL arst_data got %h want 00", bus.out_data); end
`ifdef PIPE_REG_OCC_EN
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL arst_occ got %0d want 0", occ); end
`endif
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 8'hF1, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.out_valid !== (c == 4) || (c == 4 && bus.out_data !== 8'hF1)) begin errors++; $display("FAIL arst_after c=%0d got v=%0b d=%h want v=%0b d=f1", c, bus.out_valid, bus.out_data, c == 4); end
    end
  endtask

  task automatic test_depth1;
    logic ev;
    for (int c = 0; c < 5; c++) begin
      drive1(c < 3, 8'(8'h11 * (c + 1)), 1'b1);
      @(negedge clk);
      ev = (c >= 1 && c <= 3);
      checks++; if (bus1.out_valid !== ev || (ev && bus1.out_data !== 8'(8'h11 * c))) begin errors++; $display("FAIL d1_latency c=%0d got v=%0b d=%h want v=%0b d=%h", c, bus1.out_valid, bus1.out_data, ev, 8'(8'h11 * c)); end
    end
    drive1(1'b1, 8'h44, 1'b0);
    @(negedge clk);
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL d1_empty_ready got %0b want 1", bus1.in_ready); end
    drive1(1'b1, 8'h55, 1'b0);
    @(negedge clk);
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL d1_stall_ready got %0b want 0", bus1.in_ready); end
    checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'h44) begin errors++; $display("FAIL d1_hold got v=%0b d=%h want v=1 d=44", bus1.out_valid, bus1.out_data); end
`ifdef PIPE_REG_OCC_EN
    checks++; if (occ1 !== 1'b1) begin errors++; $display("FAIL d1_occ got %0d want 1", occ1); end
`endif
    drive1(1'b1, 8'h55, 1'b1);
    @(negedge clk);
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL d1_pass_ready got %0b want 1", bus1.in_ready); end
    drive1(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'h55) begin errors++; $display("FAIL d1_next got v=%0b d=%h want v=1 d=55", bus1.out_valid, bus1.out_data); end
    drive1(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL d1_empty got %0b want 0", bus1.out_valid); end
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.out_ready = 1'b0;
    test_reset;
    test_latency;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_flush;
    test_async_reset;
    test_depth1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data bits per stage (legal range 1 or more).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of register stages (legal range 1 or more).
REQ-003 Port clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous clear of all stage valid bits.
REQ-006 Port in_valid  input  1  upstream word present.
REQ-007 Port in_data  input  WIDTH  upstream word.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port out_valid  output  1  word present at the output stage.
REQ-010 Port out_data  output  WIDTH  output-stage word.
REQ-011 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 Port occ  output  $clog2(DEPTH+1)  number of valid stages; present only with PIPE_REG_OCC_EN.

Function
REQ-013 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold data[i] (WIDTH bits) and valid bit v[i].
REQ-014 Ready chain: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush.
REQ-015 When rdy[i] is high, stage i SHALL load from the previous stage: data[i-1], v[i-1], or in_data and in_valid for stage 0.
REQ-016 When rdy[i] is low, stage i SHALL hold data[i] and v[i] unchanged.
REQ-017 out_valid = v[DEPTH-1] and out_data = data[DEPTH-1], driven directly from registers with no combinational path from inputs.
REQ-018 Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-019 A data stage SHALL NOT load while its incoming valid is low, so data holds its last value and toggling is reduced.
REQ-020 Bubbles SHALL collapse: an empty stage downstream of a stalled output still accepts from upstream.
REQ-021 Latency: on an unstalled pipe, a word transferred in cycle 0 SHALL appear with out_valid high in cycle DEPTH.
REQ-022 Throughput SHALL be one word per cycle when out_ready is held high.
REQ-023 Full (all v high): when out_ready is low, in_ready SHALL be 0; when out_ready is high, in_ready SHALL be 1 and the pipe shifts with a simultaneous input and output transfer.
REQ-024 Empty (all v low): in_ready SHALL be 1 unless flush is high, and out_valid SHALL be 0.
REQ-025 Word order SHALL be preserved, with no duplication and no loss, under any in_valid/out_ready pattern.
REQ-026 flush high SHALL clear all v[i] at the next edge, take precedence over any transfer, and drop any concurrent input (in_ready = 0 during flush).
REQ-027 flush SHALL leave the data registers unchanged.
REQ-028 DEPTH=1 SHALL behave as a single-entry register slice with in_ready = !v[0] | out_ready.

Reset
REQ-029 rst high SHALL immediately, without a clock, force all v[i]=0 and data[i]=0, so out_valid=0, out_data=0 and occ=0.
REQ-030 rst SHALL override flush and any transfer.
REQ-031 A word in flight when rst asserts SHALL be discarded.
REQ-032 The first accepted word after rst deasserts SHALL follow REQ-021 latency exactly.

Configuration
REQ-033 With macro PIPE_REG_OCC_EN defined, port occ SHALL exist.
REQ-034 occ SHALL be registered and equal the count of set v[i] after each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, 0 after flush or rst.
REQ-035 Without PIPE_REG_OCC_EN, port occ and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 WIDTH=8, DEPTH=4, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_valid high in cycles 4,5,6 with out_data 0x11,0x22,0x33.
REQ-037 out_ready=0, send 5 words 0xA0..0xA4 -> 4 accepted, in_ready=0 in cycle 4, occ=4; then out_ready=1 -> 0xA0..0xA3 drain in order, then 0xA4 accepted.
REQ-038 Full pipe with out_ready=1 and in_valid=1 held 8 cycles -> one transfer in and one out every cycle; occ remains 4.
REQ-039 Random in_valid and out_ready at 50% each for 10000 cycles -> scoreboard matches sequence exactly; occ never exceeds 4.
REQ-040 3 words resident, flush pulsed with in_valid=1 -> next cycle out_valid=0, occ=0, input word not delivered.
REQ-041 rst asserted mid-cycle with 2 words resident -> out_valid=0 and out_data=0 before the next clk edge; DEPTH=1 build repeats REQ-036 with latency 1.
